// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin share of the VGA adapter plot port among N_REQ drawing engines
//
// Ports:
//   clk, rst_n        system clock; synchronous active-low reset
//   freeze            1 = grant nothing this cycle
//   req               per-requester pixel request
//   req_x/y/colour    packed pixel fields, requester i at [8i+:8] / [7i+:7] / [3i+:3]
//   gnt               one-hot combinational grant; transfer when req[i] & gnt[i]
//   vga_x/y/colour    registered pixel to the VGA adapter
//   vga_plot          registered plot strobe, high one cycle after an in-frame transfer
//   plot_count        saturating count of plotted pixels
//   clip_count        saturating count of out-of-frame pixels that were accepted but dropped
module vga_plot_arbiter #(
  parameter int N_REQ = 3,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_x,
  input  logic [7*N_REQ-1:0] req_y,
  input  logic [3*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic [15:0]        plot_count,
  output logic [15:0]        clip_count
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] ptr, g, idx;
  logic any, xfer, in_frame;
  logic [7:0] xs [N_REQ];
  logic [6:0] ys [N_REQ];
  logic [2:0] cs [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign xs[i] = req_x[8*i +: 8];
    assign ys[i] = req_y[7*i +: 7];
    assign cs[i] = req_colour[3*i +: 3];
  end
  // Scan from the farthest offset down to ptr so the nearest requester at or after ptr wins.
  always_comb begin
    g = ptr;
    idx = ptr;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
  assign xfer = any & ~freeze & rst_n;
  assign in_frame = (int'(xs[g]) < X_MAX) && (int'(ys[g]) < Y_MAX);
  always_comb begin
    gnt = '0;
    if (xfer) gnt[g] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      plot_count <= '0;
      clip_count <= '0;
    end else begin
      vga_plot <= xfer & in_frame;
      if (xfer) ptr <= (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
      if (xfer && in_frame) begin
        vga_x      <= xs[g];
        vga_y      <= ys[g];
        vga_colour <= cs[g];
        if (plot_count != 16'hFFFF) plot_count <= plot_count + 16'd1;
      end
      if (xfer && !in_frame && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
    end
  end
endmodule
